// File: rtl/count_sequencer_pkg.sv
// Shared types and default widths for the count sequencer and its counter.
package count_sequencer_pkg;

  localparam int N_DEF = 6;
  localparam int R_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    COUNT = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/count_sequencer.sv
// Sequences a loadable up-counter through start_value..bound for a number of rounds,
// with pause, abort and one-cycle done/aborted pulses.
//
// state | meaning
// IDLE  | waiting for start; latched values held
// LOAD  | counter parallel-load strobe for one cycle
// COUNT | incrementing until W reaches the latched bound
// DONE  | one-cycle completion pulse, then back to IDLE
module count_sequencer
  import count_sequencer_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int R = R_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         pause,
  input  logic         abort,
  input  logic [N-1:0] start_value,
  input  logic [N-1:0] bound,
  input  logic [R-1:0] rounds,
  input  logic         co,
  input  logic [N-1:0] W,
  output logic         load,
  output logic         en,
  output logic [N-1:0] par_load,
  output logic [N-1:0] upper_bound,
  output logic         busy,
  output logic         done,
  output logic         aborted,
  output logic [R-1:0] round_idx
);

  state_e       state_q, state_d;
  logic [N-1:0] par_load_q, par_load_d;
  logic [N-1:0] upper_bound_q, upper_bound_d;
  logic [R-1:0] rounds_q, rounds_d;
  logic [R-1:0] round_idx_q, round_idx_d;
  logic         aborted_q, aborted_d;

  logic abort_take;
  logic round_done;
  logic last_round;

  assign abort_take = abort & (state_q != IDLE);
  // co is trusted only when the counter value agrees with our latched bound.
  assign round_done = (state_q == COUNT) & co & (W == upper_bound_q);
  assign last_round = (round_idx_q == rounds_q - R'(1));

  always_comb begin
    state_d       = state_q;
    par_load_d    = par_load_q;
    upper_bound_d = upper_bound_q;
    rounds_d      = rounds_q;
    round_idx_d   = round_idx_q;
    aborted_d     = 1'b0;
    if (abort_take) begin
      state_d   = IDLE;
      aborted_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            round_idx_d = '0;
            if (rounds != '0) begin
              par_load_d    = start_value;
              upper_bound_d = bound;
              rounds_d      = rounds;
              state_d       = LOAD;
            end else begin
              state_d = DONE;
            end
          end
        end
        LOAD:  state_d = COUNT;
        COUNT: begin
          if (round_done) begin
            if (last_round) begin
              state_d = DONE;
            end else begin
              round_idx_d = round_idx_q + R'(1);
              state_d     = LOAD;
            end
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      par_load_q    <= '0;
      upper_bound_q <= '0;
      rounds_q      <= '0;
      round_idx_q   <= '0;
      aborted_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      par_load_q    <= par_load_d;
      upper_bound_q <= upper_bound_d;
      rounds_q      <= rounds_d;
      round_idx_q   <= round_idx_d;
      aborted_q     <= aborted_d;
    end
  end

  // Strobes react in the same cycle so an abort or terminal count stops the counter at once.
  assign load        = (state_q == LOAD) & ~abort_take & ~reset;
  assign en          = (state_q == COUNT) & ~pause & ~round_done & ~abort_take & ~reset;
  assign done        = (state_q == DONE) & ~abort_take & ~reset;
  assign busy        = (state_q != IDLE);
  assign aborted     = aborted_q;
  assign par_load    = par_load_q;
  assign upper_bound = upper_bound_q;
  assign round_idx   = round_idx_q;

endmodule

// File: tb/tb_count_sequencer.sv
// Directed bench for count_sequencer driving a behavioural loadable up-counter.
module tb_count_sequencer;

  localparam int N = 6;
  localparam int R = 4;
  localparam logic [N-1:0] ONE = 1;

  logic         clk = 1'b0;
  logic         reset, start, pause, abort;
  logic [N-1:0] start_value, bound;
  logic [R-1:0] rounds;
  logic         co;
  logic [N-1:0] w_q;
  logic         load, en, busy, done, aborted;
  logic [N-1:0] par_load, upper_bound;
  logic [R-1:0] round_idx;

  int n_vec = 0;
  int n_err = 0;
  int n_load = 0, n_en = 0, n_done = 0;
  int w_max = 0, ridx_max = 0;
  int base_load, base_en, base_done, cyc;

  always #5 clk = ~clk;

  count_sequencer #(.N(N), .R(R)) dut (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .abort(abort),
    .start_value(start_value), .bound(bound), .rounds(rounds),
    .co(co), .W(w_q),
    .load(load), .en(en), .par_load(par_load), .upper_bound(upper_bound),
    .busy(busy), .done(done), .aborted(aborted), .round_idx(round_idx)
  );

  always_ff @(posedge clk) begin
    if (reset)     w_q <= '0;
    else if (load) w_q <= par_load;
    else if (en)   w_q <= w_q + ONE;
  end
  assign co = (w_q == upper_bound);

  always @(negedge clk) begin
    if (start) begin
      w_max    = 0;
      ridx_max = 0;
    end
    if (load) n_load++;
    if (en)   n_en++;
    if (done) n_done++;
    if (busy && !load && int'(w_q) > w_max) w_max = int'(w_q);
    if (int'(round_idx) > ridx_max) ridx_max = int'(round_idx);
  end

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int budget, output int n);
    n = 0;
    while (n < budget) begin
      tick();
      n++;
      if (done) break;
    end
  endtask

  task automatic kick(input int sv, input int bd, input int rn);
    start_value = N'(sv);
    bound       = N'(bd);
    rounds      = R'(rn);
    base_load   = n_load;
    base_en     = n_en;
    base_done   = n_done;
    start       = 1'b1;
    tick();
    start = 1'b0;
    #1;
  endtask

  initial begin
    automatic int wrap_exp[4] = '{62, 63, 0, 1};
    reset = 1'b1; start = 1'b0; pause = 1'b0; abort = 1'b0;
    start_value = '0; bound = '0; rounds = '0;
    repeat (2) tick();
    reset = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_load", load, 0);
    check("rst_en", en, 0);
    check("rst_done", done, 0);
    check("rst_aborted", aborted, 0);
    check("rst_ridx", round_idx, 0);
    check("rst_par_load", par_load, 0);
    check("rst_upper_bound", upper_bound, 0);

    // single round 3..7
    kick(3, 7, 1);
    check("sr_load", load, 1);
    check("sr_en_in_load", en, 0);
    check("sr_par_load", par_load, 3);
    check("sr_upper_bound", upper_bound, 7);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("sr_w", w_q, 3 + k);
      check("sr_en", en, (k < 4) ? 1 : 0);
      check("sr_load_off", load, 0);
    end
    tick();
    check("sr_done", done, 1);
    check("sr_busy_in_done", busy, 1);
    tick();
    check("sr_done_once", done, 0);
    check("sr_busy_after", busy, 0);
    check("sr_loads", n_load - base_load, 1);

    // three rounds of 0..2 with a pause in round 1
    kick(0, 2, 3);
    repeat (4) tick();
    check("mr_ridx1", round_idx, 1);
    check("mr_reload", load, 1);
    tick();
    check("mr_w0", w_q, 0);
    check("mr_en", en, 1);
    pause = 1'b1;
    #1;
    check("mr_pause_en", en, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("mr_pause_w", w_q, 0);
    end
    pause = 1'b0;
    wait_done(40, cyc);
    check("mr_done_latency", cyc, 7);
    tick();
    check("mr_loads", n_load - base_load, 3);
    check("mr_dones", n_done - base_done, 1);
    check("mr_w_max", w_max, 2);
    check("mr_ridx_max", ridx_max, 2);
    check("mr_busy_after", busy, 0);

    // start == bound, two rounds
    kick(5, 5, 2);
    wait_done(40, cyc);
    check("eq_done_latency", cyc, 4);
    tick();
    check("eq_loads", n_load - base_load, 2);
    check("eq_incs", n_en - base_en, 0);

    // zero rounds
    kick(9, 12, 0);
    check("z_done", done, 1);
    check("z_busy", busy, 1);
    tick();
    check("z_done_once", done, 0);
    check("z_busy_after", busy, 0);
    check("z_loads", n_load - base_load, 0);

    // wrap 62 -> 1
    kick(62, 1, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("wr_w", w_q, wrap_exp[i]);
      check("wr_en", en, (i < 3) ? 1 : 0);
    end
    tick();
    check("wr_done", done, 1);
    tick();

    // abort at W=4 with a start attempted mid-run
    kick(0, 10, 1);
    repeat (3) tick();
    start_value = N'(9); bound = N'(20); rounds = R'(5);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("ab_ub_held", upper_bound, 10);
    check("ab_par_held", par_load, 0);
    check("ab_busy", busy, 1);
    tick();
    check("ab_w4", w_q, 4);
    abort = 1'b1;
    #1;
    check("ab_en_now", en, 0);
    check("ab_load_now", load, 0);
    tick();
    abort = 1'b0;
    check("ab_pulse", aborted, 1);
    check("ab_idle", busy, 0);
    check("ab_no_done", done, 0);
    check("ab_w_frozen", w_q, 4);
    tick();
    check("ab_pulse_once", aborted, 0);
    check("ab_dones", n_done - base_done, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ab_idle_ignored", aborted, 0);
    check("ab_idle_busy", busy, 0);

    // reset mid-run, then a normal run
    kick(1, 9, 2);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("rr_busy", busy, 0);
    check("rr_load", load, 0);
    check("rr_en", en, 0);
    check("rr_done", done, 0);
    check("rr_aborted", aborted, 0);
    check("rr_ridx", round_idx, 0);
    check("rr_par_load", par_load, 0);
    check("rr_upper_bound", upper_bound, 0);
    tick();
    check("rr_no_pulse", aborted + done, 0);
    check("rr_dones", n_done - base_done, 0);
    kick(3, 7, 1);
    wait_done(40, cyc);
    check("rr_rerun_latency", cyc, 6);
    tick();
    check("rr_rerun_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
